hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central hazard and sequencing controller for the five-stage MIPS pipeline.
- Detects load-use hazards that write-back bypassing cannot cover.
- Sequences the multi-cycle HI/LO multiply/divide unit: issue, busy count, done.
- Drives PC / IF/ID write enables and IF/ID / ID/EX flushes, with taken-branch flush priority.

Parameters:
MULT_CYCLES, 4, busy cycles for mult/multu (>=1)
DIV_CYCLES, 32, busy cycles for div/divu (>=1)
CNT_W, 6, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous active-high reset
BranchTaken_ex  input  1  branch/jump resolved taken in EX
MemRead_ex  input  1  EX-stage instruction is a load
RegWriteAddr_ex  input  5  EX-stage destination register
RsAddr_id  input  5  ID-stage rs
RtAddr_id  input  5  ID-stage rt
RsRead_id  input  1  ID instruction reads rs
RtRead_id  input  1  ID instruction reads rt
MdReq_id  input  1  ID instruction is mult/multu/div/divu
MdIsDiv_id  input  1  ID multiply/divide request is a divide
HiLoRead_id  input  1  ID instruction is mfhi/mflo
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register write enable
IFIDFlush  output  1  IF/ID bubble insert
IDEXFlush  output  1  ID/EX bubble insert
MdIssue  output  1  start pulse to multiply/divide unit
MdBusy  output  1  multiply/divide unit occupied
MdDone  output  1  final busy cycle; HI/LO written at this edge
LoadUseStall  output  1  load-use stall active (status)
MdStall  output  1  HI/LO structural stall active (status)

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: state IDLE, counter 0. With inputs at 0: PCWrite=1, IFIDWrite=1, all flushes 0, MdIssue/MdBusy/MdDone 0.
- Reset asserted mid-operation: the counter clears immediately and no MdDone is produced.
- Stall outputs are combinational from registered state plus current inputs. No extra latency.
- FSM states:
  - IDLE to BUSY on MdIssue. Load counter with DIV_CYCLES if MdIsDiv_id, else MULT_CYCLES.
  - BUSY: counter decrements every cycle.
  - When counter==1 in BUSY: MdDone=1, then next state IDLE with counter 0.
- MdBusy = (state==BUSY).
- LoadUse = MemRead_ex & (RegWriteAddr_ex!=0) & ((RsRead_id & RsAddr_id==RegWriteAddr_ex) | (RtRead_id & RtAddr_id==RegWriteAddr_ex)).
- MdHaz = MdBusy & (MdReq_id | HiLoRead_id). This includes the MdDone cycle.
- Stall = (LoadUse | MdHaz) & ~BranchTaken_ex.
- LoadUseStall = LoadUse & ~BranchTaken_ex.
- MdStall = MdHaz & ~BranchTaken_ex.
- On Stall: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0.
- BranchTaken_ex has highest priority:
  - PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1.
  - No stall and no MdIssue that cycle.
- MdIssue = MdReq_id & ~MdBusy & ~LoadUse & ~BranchTaken_ex. It is a one-cycle pulse; MdBusy rises the following cycle.
- Taken branch while BUSY: the in-flight operation continues to completion (it is older than the branch).
- A multiply/divide request stalled by BUSY issues in the first cycle after MdDone. Back-to-back operations therefore have exactly one IDLE cycle between them.
- Load-use and HI/LO hazard in the same cycle: a single stall. Both status bits are set.

Optional Feature:
- Macro: HAZARD_STALL_CTR_EN.
- When defined, add output StallCount [31:0]:
  - Cleared on rst.
  - Increments on every cycle with Stall=1.
  - Wraps modulo 2^32.
  - A stall that lasts N cycles adds N.
- When not defined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Load-use on rs: MemRead_ex=1, RegWriteAddr_ex=8, RsRead_id=1, RsAddr_id=8 -> PCWrite=0, IFIDWrite=0, IDEXFlush=1, LoadUseStall=1 for exactly that cycle.
- $zero exclusion: same as above with RegWriteAddr_ex=0 and RsAddr_id=0 -> no stall; PCWrite=1.
- Mult then mfhi: MdReq_id=1, MdIsDiv_id=0 for 1 cycle, then HiLoRead_id=1 -> MdIssue pulse; MdBusy high 4 cycles; MdStall=1 for those 4 cycles; MdDone on the 4th; mfhi proceeds the next cycle.
- Div then back-to-back mult held in ID -> MdBusy 32 cycles; the mult stalls 32 cycles, issues on cycle 33, then busy 4 more.
- Branch priority: BranchTaken_ex=1 with a simultaneous load-use hazard -> IFIDFlush=1, IDEXFlush=1, PCWrite=1, LoadUseStall=0, no MdIssue.
- Reset mid-divide: assert rst at busy cycle 10 -> MdBusy=0 immediately, no MdDone; the next mult issues normally. With HAZARD_STALL_CTR_EN, StallCount=0 after reset.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS pipeline: load-use
// detection, HI/LO multiply/divide sequencing, stall/flush generation.
// Optional stall counter output enabled by defining HAZARD_STALL_CTR_EN.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BranchTaken_ex,
    input  logic       MemRead_ex,
    input  logic [4:0] RegWriteAddr_ex,
    input  logic [4:0] RsAddr_id,
    input  logic [4:0] RtAddr_id,
    input  logic       RsRead_id,
    input  logic       RtRead_id,
    input  logic       MdReq_id,
    input  logic       MdIsDiv_id,
    input  logic       HiLoRead_id,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFIDFlush,
    output logic       IDEXFlush,
    output logic       MdIssue,
    output logic       MdBusy,
    output logic       MdDone,
    output logic       LoadUseStall,
    output logic       MdStall
`ifdef HAZARD_STALL_CTR_EN
    ,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic md_busy;
    logic md_done;
    logic md_haz;
    logic md_issue;
    logic stall;

    // Hazard terms; a taken branch squashes the ID instruction, so it wins over both.
    always_comb begin
        load_use = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                   ((RsRead_id && (RsAddr_id == RegWriteAddr_ex)) ||
                    (RtRead_id && (RtAddr_id == RegWriteAddr_ex)));
        md_busy  = (state_q == BUSY);
        md_done  = md_busy && (cnt_q == CNT_W'(1));
        md_haz   = md_busy && (MdReq_id || HiLoRead_id);
        stall    = (load_use || md_haz) && !BranchTaken_ex;
        md_issue = MdReq_id && !md_busy && !load_use && !BranchTaken_ex;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_issue) begin
                    state_d = BUSY;
                    cnt_d   = MdIsDiv_id ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCWrite      = !stall;
    assign IFIDWrite    = !stall;
    assign IFIDFlush    = BranchTaken_ex;
    assign IDEXFlush    = BranchTaken_ex || stall;
    assign MdIssue      = md_issue;
    assign MdBusy       = md_busy;
    assign MdDone       = md_done;
    assign LoadUseStall = load_use && !BranchTaken_ex;
    assign MdStall      = md_haz && !BranchTaken_ex;

`ifdef HAZARD_STALL_CTR_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: constant vector table, directed multi-cycle
// sequences and randomized traffic against a cycle-timestamp reference model.
module tb_hazard_stall_ctrl;

    localparam int MULT_CYC = 4;
    localparam int DIV_CYC  = 32;

    logic       clk;
    logic       rst;
    logic       BranchTaken_ex, MemRead_ex;
    logic [4:0] RegWriteAddr_ex, RsAddr_id, RtAddr_id;
    logic       RsRead_id, RtRead_id, MdReq_id, MdIsDiv_id, HiLoRead_id;
    logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush;
    logic       MdIssue, MdBusy, MdDone, LoadUseStall, MdStall;
`ifdef HAZARD_STALL_CTR_EN
    logic [31:0] StallCount;
`endif

    hazard_stall_ctrl #(
        .MULT_CYCLES(MULT_CYC),
        .DIV_CYCLES (DIV_CYC),
        .CNT_W      (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .BranchTaken_ex (BranchTaken_ex),
        .MemRead_ex     (MemRead_ex),
        .RegWriteAddr_ex(RegWriteAddr_ex),
        .RsAddr_id      (RsAddr_id),
        .RtAddr_id      (RtAddr_id),
        .RsRead_id      (RsRead_id),
        .RtRead_id      (RtRead_id),
        .MdReq_id       (MdReq_id),
        .MdIsDiv_id     (MdIsDiv_id),
        .HiLoRead_id    (HiLoRead_id),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IFIDFlush      (IFIDFlush),
        .IDEXFlush      (IDEXFlush),
        .MdIssue        (MdIssue),
        .MdBusy         (MdBusy),
        .MdDone         (MdDone),
        .LoadUseStall   (LoadUseStall),
        .MdStall        (MdStall)
`ifdef HAZARD_STALL_CTR_EN
        ,
        .StallCount     (StallCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       bt;
        logic       mr;
        logic [4:0] wa;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rsr;
        logic       rtr;
        logic       mdreq;
        logic       isdiv;
        logic       hilo;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MdIssue, MdBusy, MdDone, LoadUseStall, MdStall}
    logic [8:0] obs;
    assign obs = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MdIssue, MdBusy, MdDone, LoadUseStall, MdStall};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the unit is busy for the cycles strictly after the issue
    // cycle up to and including busy_end.
    longint      cyc      = 0;
    longint      iss_cyc  = -1;
    longint      busy_end = -1;
    logic [31:0] sc_model = 0;
    logic [8:0]  last_obs;

    function automatic in_t mk(logic bt, logic mr, logic [4:0] wa, logic [4:0] rs, logic [4:0] rt,
                               logic rsr, logic rtr, logic mdreq, logic isdiv, logic hilo);
        in_t v;
        v.bt = bt; v.mr = mr; v.wa = wa; v.rs = rs; v.rt = rt;
        v.rsr = rsr; v.rtr = rtr; v.mdreq = mdreq; v.isdiv = isdiv; v.hilo = hilo;
        return v;
    endfunction

    function automatic logic [8:0] model_outputs(in_t v);
        logic lu, busy, done, mh, st, iss;
        lu   = v.mr && (v.wa != 0) && ((v.rsr && v.rs == v.wa) || (v.rtr && v.rt == v.wa));
        busy = (cyc > iss_cyc) && (cyc <= busy_end);
        done = busy && (cyc == busy_end);
        mh   = busy && (v.mdreq || v.hilo);
        st   = (lu || mh) && !v.bt;
        iss  = v.mdreq && !busy && !lu && !v.bt;
        return {v.bt || !st, v.bt || !st, v.bt, v.bt || st, iss, busy, done,
                lu && !v.bt, mh && !v.bt};
    endfunction

    task automatic reset_model();
        iss_cyc  = -1;
        busy_end = -1;
        sc_model = 0;
    endtask

    task automatic apply_stimulus(in_t v);
        BranchTaken_ex  = v.bt;
        MemRead_ex      = v.mr;
        RegWriteAddr_ex = v.wa;
        RsAddr_id       = v.rs;
        RtAddr_id       = v.rt;
        RsRead_id       = v.rsr;
        RtRead_id       = v.rtr;
        MdReq_id        = v.mdreq;
        MdIsDiv_id      = v.isdiv;
        HiLoRead_id     = v.hilo;
    endtask

    task automatic check_output(string name, logic [8:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got outputs %b, expected %b (t=%0t)", name, obs, exp, $time);
        end
    endtask

    task automatic check_int(string name, longint got, longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Called just after a rising edge; leaves the bench just after the next one.
    task automatic run_cycle(string name, in_t v);
        logic [8:0] exp;
        apply_stimulus(v);
        @(negedge clk);
        exp = model_outputs(v);
        check_output(name, exp);
`ifdef HAZARD_STALL_CTR_EN
        check_int({name, "_stallcount"}, StallCount, sc_model);
`endif
        last_obs = obs;
        @(posedge clk);
        if (exp[4]) begin
            iss_cyc  = cyc;
            busy_end = cyc + (v.isdiv ? DIV_CYC : MULT_CYC);
        end
        if (!exp[8]) sc_model = sc_model + 32'd1;
        cyc++;
        #1;
    endtask

    task automatic pulse_reset(string name, in_t v);
        apply_stimulus(v);
        rst = 1'b1;
        #1;
        reset_model();
        check_output(name, model_outputs(v));
`ifdef HAZARD_STALL_CTR_EN
        check_int({name, "_stallcount"}, StallCount, 0);
`endif
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
    endtask

    vec_t vecs[11];
    in_t  idle_in;

    initial begin
        int stalls, waited, busy_n, done_n, issued;
        idle_in = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(idle_in);
        rst = 1'b1;

        vecs[0]  = '{"idle",          mk(0,0,0,0,0,0,0,0,0,0), 9'b110000000};
        vecs[1]  = '{"loaduse_rs",    mk(0,1,8,8,0,1,0,0,0,0), 9'b000100010};
        vecs[2]  = '{"zero_excl",     mk(0,1,0,0,0,1,0,0,0,0), 9'b110000000};
        vecs[3]  = '{"loaduse_rt",    mk(0,1,5,3,5,1,1,0,0,0), 9'b000100010};
        vecs[4]  = '{"rt_not_read",   mk(0,1,5,3,5,1,0,0,0,0), 9'b110000000};
        vecs[5]  = '{"no_memread",    mk(0,0,8,8,8,1,1,0,0,0), 9'b110000000};
        vecs[6]  = '{"branch_lu",     mk(1,1,8,8,0,1,0,0,0,0), 9'b111100000};
        vecs[7]  = '{"md_issue_idle", mk(0,0,0,0,0,0,0,1,0,0), 9'b110010000};
        vecs[8]  = '{"md_lu_block",   mk(0,1,9,0,9,0,1,1,1,0), 9'b000100010};
        vecs[9]  = '{"md_branch",     mk(1,0,0,0,0,0,0,1,0,0), 9'b111100000};
        vecs[10] = '{"hilo_idle",     mk(0,0,0,0,0,0,0,0,0,1), 9'b110000000};

        // Reset state, then combinational vectors with the FSM held in IDLE by reset.
        @(negedge clk);
        check_output("reset_state", 9'b110000000);
`ifdef HAZARD_STALL_CTR_EN
        check_int("reset_stallcount", StallCount, 0);
`endif
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            apply_stimulus(vecs[i].in);
            @(negedge clk);
            check_output(vecs[i].name, vecs[i].exp);
        end

        @(posedge clk);
        #1;
        apply_stimulus(idle_in);
        reset_model();
        rst = 1'b0;

        // Mult followed by mfhi held in ID.
        run_cycle("mult_issue", mk(0,0,0,0,0,0,0,1,0,0));
        check_int("mult_issue_pulse", last_obs[4], 1);
        stalls = 0; done_n = 0;
        for (int i = 0; i < MULT_CYC; i++) begin
            run_cycle("mfhi_wait", mk(0,0,0,0,0,0,0,0,0,1));
            stalls += int'(last_obs[0]);
            done_n += int'(last_obs[2]);
            if (i == MULT_CYC - 1) check_int("mult_done_last", last_obs[2], 1);
        end
        check_int("mfhi_stall_cycles", stalls, MULT_CYC);
        check_int("mult_done_count", done_n, 1);
        run_cycle("mfhi_go", mk(0,0,0,0,0,0,0,0,0,1));
        check_int("mfhi_proceeds", last_obs[8], 1);

        // Divide with a mult held back-to-back in ID.
        run_cycle("div_issue", mk(0,0,0,0,0,0,0,1,1,0));
        check_int("div_issue_pulse", last_obs[4], 1);
        stalls = 0; waited = 0; issued = 0;
        for (int i = 0; i < 100 && issued == 0; i++) begin
            run_cycle("mult_behind_div", mk(0,0,0,0,0,0,0,1,0,0));
            waited++;
            if (last_obs[4]) issued = 1;
            else if (last_obs[0]) stalls++;
        end
        check_int("b2b_issued", issued, 1);
        check_int("b2b_stall_cycles", stalls, DIV_CYC);
        check_int("b2b_issue_cycle", waited, DIV_CYC + 1);
        busy_n = 0;
        for (int i = 0; i < 50; i++) begin
            run_cycle("b2b_mult_busy", idle_in);
            if (!last_obs[3]) break;
            busy_n++;
        end
        check_int("b2b_mult_busy_cycles", busy_n, MULT_CYC);

        // Taken branch while busy: operation continues, request not issued.
        run_cycle("br_md_issue", mk(0,0,0,0,0,0,0,1,0,0));
        run_cycle("br_while_busy", mk(1,1,4,4,0,1,0,1,0,0));
        for (int i = 0; i < MULT_CYC; i++) run_cycle("br_drain", idle_in);

        // Reset in the middle of a divide.
        run_cycle("rdiv_issue", mk(0,0,0,0,0,0,0,1,1,0));
        for (int i = 0; i < 10; i++) run_cycle("rdiv_busy", mk(0,0,0,0,0,0,0,0,0,1));
        pulse_reset("rdiv_reset", idle_in);
        for (int i = 0; i < DIV_CYC + 2; i++) run_cycle("rdiv_after", idle_in);
        run_cycle("rdiv_mult_issue", mk(0,0,0,0,0,0,0,1,0,0));
        check_int("rdiv_mult_issue_pulse", last_obs[4], 1);
        for (int i = 0; i < MULT_CYC + 1; i++) run_cycle("rdiv_mult_run", idle_in);

        // Randomized traffic with small register numbers to provoke matches.
        for (int i = 0; i < 4000; i++) begin
            in_t v;
            v = mk($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
                   1'($urandom), $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 399) == 0) pulse_reset("rand_reset", v);
            else run_cycle("random", v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
